usbf_token_dec: RTL and testbench
=================================

USBF_TOKEN_DEC -- requirements
Module: usbf_token_dec

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 16: max idle clocks between rx_valid bytes inside a packet.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port rx_data, input, 8: received byte, qualified by rx_valid.
REQ-005 SHALL have port rx_valid, input, 1: one byte accepted per cycle when high together with rx_active.
REQ-006 SHALL have port rx_active, input, 1: high for the duration of one packet.
REQ-007 SHALL have port rx_err, input, 1: PHY receive error (bit-stuff or abort).
REQ-008 SHALL have port token_valid, output, 1: one-cycle pulse; good OUT/IN/SETUP token.
REQ-009 SHALL have port token_pid, output, 4: PID of the last good token.
REQ-010 SHALL have port token_fadr, output, 7: function address of the last good token.
REQ-011 SHALL have port token_endp, output, 4: endpoint of the last good token.
REQ-012 SHALL have ports pid_err, crc5_err, len_err, tmo_err, output, 1 each: one-cycle error pulses.

Function
REQ-013 SHALL use FSM states IDLE, PID, TK1, TK2, CHK, DROP.
REQ-014 SHALL, in IDLE, go to PID on rising rx_active.
REQ-015 SHALL, in PID, take the first byte: valid iff rx_data[7:4] == ~rx_data[3:0]; token PIDs are OUT 4'b0001, IN 4'b1001, SETUP 4'b1101, SOF 4'b0101.
REQ-016 SHALL, on a valid non-token PID, go to DROP with no output pulse; on an invalid PID, set a pending pid_err and go to DROP.
REQ-017 SHALL capture byte 1 in TK1 and byte 2 in TK2, then wait in TK2 for rx_active low.
REQ-018 SHALL form d[10:0] = {byte2[2:0], byte1[7:0]} and received field r = byte2[7:3], and SHALL treat the CRC as ok iff the usbf_crc5 output over d equals r bitwise.
REQ-019 SHALL, on rx_active low with exactly 3 bytes received, enter CHK for one cycle, then return to IDLE.
REQ-020 SHALL, in CHK with CRC ok, pulse token_valid and load token_pid, token_fadr = d[6:0] and token_endp = d[10:7] in that same cycle; latency is 1 clock after rx_active is sampled low.
REQ-021 SHALL, in CHK with CRC bad, pulse crc5_err and leave the token fields unchanged.
REQ-022 SHALL treat a 4th byte, or rx_active low after fewer than 3 bytes, as len_err: pulse it when rx_active goes low (DROP exit), then go to IDLE.
REQ-023 SHALL, on rx_err at any point in a packet, go to DROP and suppress all pulses, including pending ones, for that packet.
REQ-024 SHALL count idle cycles between bytes while rx_active is high; when the count reaches TMO_CYCLES, pulse tmo_err once and go to DROP.
REQ-025 SHALL, in DROP, ignore bytes until rx_active is low, pulse any pending pid_err or len_err on exit, then go to IDLE.
REQ-026 SHALL hold token fields between good tokens; at most one pulse of any output per packet.

Reset
REQ-027 SHALL, on rst, asynchronously force state IDLE, zero all counters, and drive all outputs and token fields to 0.
REQ-028 SHALL, on reset mid-packet, discard the packet; the remainder of that packet is dropped until rx_active is low.

Configuration
REQ-029 SHALL, with USBF_TOKEN_SOF_EN defined, decode SOF like a token (same CRC check) and add output frame_no (11) = d with a one-cycle sof_valid pulse, both reset to 0.
REQ-030 SHALL, without USBF_TOKEN_SOF_EN, treat SOF as a valid non-token PID (silent DROP); frame_no and sof_valid are absent.

Structure
REQ-031 SHALL place the PID constants, FSM state encoding and the token field widths in shared package usbf_pkg.
REQ-032 SHALL instantiate exactly one sub-module, usbf_crc5 (combinational CRC5, 11-bit data in, 5-bit CRC out, init 5'b11111).

Verification
REQ-033 SHALL cover: PID 8'hE1, byte1 8'h85, byte2 with [2:0]=3'b010 and [7:3]=CRC of d -> token_valid 1 clock after rx_active low, token_fadr 7'h05, token_endp 4'h5.
REQ-034 SHALL cover: same packet with r XOR 5'b00001 -> crc5_err pulse, no token_valid, fields unchanged.
REQ-035 SHALL cover: PID byte 8'hE2 -> pid_err after rx_active low; PID 8'hC3 (DATA0) -> no pulse.
REQ-036 SHALL cover: 2-byte packet and 4-byte packet -> len_err once each; rx_err mid-packet -> no pulses.
REQ-037 SHALL cover: a gap of TMO_CYCLES=16 clocks after byte1 -> tmo_err once, then IDLE after rx_active low.
REQ-038 SHALL cover: rst pulse during TK1 -> all outputs 0; next good token decoded normally; SOF 8'hA5 per macro setting.

Source files
------------

// File: rtl/usbf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usbf_pkg
// Description : Shared constants for the USB token decoder: PID codes, field
//               widths, FSM state encoding and small PID helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package usbf_pkg;

  localparam int PID_W   = 4;
  localparam int FADR_W  = 7;
  localparam int ENDP_W  = 4;
  localparam int FRAME_W = 11;

  localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
  localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
  localparam logic [PID_W-1:0] PID_SETUP = 4'b1101;
  localparam logic [PID_W-1:0] PID_SOF   = 4'b0101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PID  = 3'd1,
    TK1  = 3'd2,
    TK2  = 3'd3,
    CHK  = 3'd4,
    DROP = 3'd5
  } tok_state_t;

  // A PID byte carries its own complement in the upper nibble.
  function automatic logic pid_check(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  // PIDs that are followed by an address/endpoint (or frame) field plus CRC5.
  function automatic logic pid_is_token(input logic [PID_W-1:0] p);
`ifdef USBF_TOKEN_SOF_EN
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP) || (p == PID_SOF);
`else
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/usbf_crc5.sv
`default_nettype none
// ============================================================================
// Module      : usbf_crc5
// Description : Combinational USB CRC5 (x^5 + x^2 + 1) over an 11-bit token
//               field, bit 0 shifted in first, register preset to 5'b11111.
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_crc5 (
  input  logic [10:0] data,
  output logic [4:0]  crc
);

  // Unrolled bit-serial LFSR; data[0] is the first bit on the wire.
  always_comb begin : crc_calc
    logic [4:0] acc;
    logic       fb;
    acc = 5'b11111;
    fb  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb  = data[i] ^ acc[4];
      acc = {acc[3:0], 1'b0} ^ ({5{fb}} & 5'b00101);
    end
    crc = acc;
  end

endmodule
`default_nettype wire

// File: rtl/usbf_token_dec.sv
`default_nettype none
// ============================================================================
// Module      : usbf_token_dec
// Description : USB token packet decoder. Parses PID + 2 token bytes from the
//               PHY receive stream, checks PID complement, CRC5, length and
//               inter-byte timeout, and reports a good token or one error.
//               Define USBF_TOKEN_SOF_EN to also decode SOF packets
//               (adds frame_no / sof_valid outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_token_dec
  import usbf_pkg::*;
#(
  parameter int TMO_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_active,
  input  logic               rx_err,
  output logic               token_valid,
  output logic [PID_W-1:0]   token_pid,
  output logic [FADR_W-1:0]  token_fadr,
  output logic [ENDP_W-1:0]  token_endp,
  output logic               pid_err,
  output logic               crc5_err,
  output logic               len_err,
`ifdef USBF_TOKEN_SOF_EN
  output logic [FRAME_W-1:0] frame_no,
  output logic               sof_valid,
`endif
  output logic               tmo_err
);

  localparam int CNT_W = $clog2(TMO_CYCLES + 1);

  tok_state_t         state, state_n;
  logic               active_q;
  logic [PID_W-1:0]   pid_q, pid_n;
  logic [7:0]         byte1_q, byte1_n, byte2_q, byte2_n;
  logic               have_b2, have_b2_n;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_n;
  logic               pend_pid, pend_pid_n, pend_len, pend_len_n;
  logic               tv_n, pe_n, ce_n, le_n, te_n, load_tok;
  logic [10:0]        d;
  logic [4:0]         crc;
  logic               crc_ok;
`ifdef USBF_TOKEN_SOF_EN
  logic               sv_n, load_sof;
`endif

  assign d      = {byte2_q[2:0], byte1_q};
  assign crc_ok = (crc == byte2_q[7:3]);

  usbf_crc5 u_crc5 (
    .data (d),
    .crc  (crc)
  );

  // State register; active_q resets high so a packet already in flight at
  // reset release is not mistaken for a new rising rx_active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      active_q <= 1'b1;
    end else begin
      state    <= state_n;
      active_q <= rx_active;
    end
  end

  // Next-state, byte capture, idle counting and pulse decisions.
  always_comb begin
    state_n    = state;
    pid_n      = pid_q;
    byte1_n    = byte1_q;
    byte2_n    = byte2_q;
    have_b2_n  = have_b2;
    idle_cnt_n = idle_cnt;
    pend_pid_n = pend_pid;
    pend_len_n = pend_len;
    tv_n       = 1'b0;
    pe_n       = 1'b0;
    ce_n       = 1'b0;
    le_n       = 1'b0;
    te_n       = 1'b0;
    load_tok   = 1'b0;
`ifdef USBF_TOKEN_SOF_EN
    sv_n       = 1'b0;
    load_sof   = 1'b0;
`endif
    case (state)
      IDLE: begin
        idle_cnt_n = '0;
        have_b2_n  = 1'b0;
        pend_pid_n = 1'b0;
        pend_len_n = 1'b0;
        if (rx_active && !active_q) state_n = PID;
      end
      PID, TK1, TK2: begin
        if (rx_err) begin
          // A PHY error kills the packet and anything pending for it.
          pend_pid_n = 1'b0;
          pend_len_n = 1'b0;
          state_n    = DROP;
        end else if (!rx_active) begin
          if (state == TK2 && have_b2) begin
            state_n = CHK;
          end else begin
            le_n    = 1'b1;
            state_n = IDLE;
          end
        end else if (rx_valid) begin
          idle_cnt_n = '0;
          if (state == PID) begin
            if (!pid_check(rx_data)) begin
              pend_pid_n = 1'b1;
              state_n    = DROP;
            end else if (pid_is_token(rx_data[3:0])) begin
              pid_n   = rx_data[3:0];
              state_n = TK1;
            end else begin
              state_n = DROP;
            end
          end else if (state == TK1) begin
            byte1_n = rx_data;
            state_n = TK2;
          end else if (!have_b2) begin
            byte2_n   = rx_data;
            have_b2_n = 1'b1;
          end else begin
            pend_len_n = 1'b1;
            state_n    = DROP;
          end
        end else if (idle_cnt == CNT_W'(TMO_CYCLES - 1)) begin
          te_n    = 1'b1;
          state_n = DROP;
        end else begin
          idle_cnt_n = idle_cnt + CNT_W'(1);
        end
      end
      CHK: begin
        state_n = IDLE;
        if (!crc_ok) begin
          ce_n = 1'b1;
`ifdef USBF_TOKEN_SOF_EN
        end else if (pid_q == PID_SOF) begin
          sv_n     = 1'b1;
          load_sof = 1'b1;
`endif
        end else begin
          tv_n     = 1'b1;
          load_tok = 1'b1;
        end
      end
      DROP: begin
        if (rx_err) begin
          pend_pid_n = 1'b0;
          pend_len_n = 1'b0;
        end
        if (!rx_active) begin
          pe_n       = pend_pid && !rx_err;
          le_n       = pend_len && !rx_err;
          pend_pid_n = 1'b0;
          pend_len_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Packet working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_q    <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
      have_b2  <= 1'b0;
      idle_cnt <= '0;
      pend_pid <= 1'b0;
      pend_len <= 1'b0;
    end else begin
      pid_q    <= pid_n;
      byte1_q  <= byte1_n;
      byte2_q  <= byte2_n;
      have_b2  <= have_b2_n;
      idle_cnt <= idle_cnt_n;
      pend_pid <= pend_pid_n;
      pend_len <= pend_len_n;
    end
  end

  // Registered pulses and held token fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      token_valid <= 1'b0;
      token_pid   <= '0;
      token_fadr  <= '0;
      token_endp  <= '0;
      pid_err     <= 1'b0;
      crc5_err    <= 1'b0;
      len_err     <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      token_valid <= tv_n;
      pid_err     <= pe_n;
      crc5_err    <= ce_n;
      len_err     <= le_n;
      tmo_err     <= te_n;
      if (load_tok) begin
        token_pid  <= pid_q;
        token_fadr <= d[6:0];
        token_endp <= d[10:7];
      end
    end
  end

`ifdef USBF_TOKEN_SOF_EN
  // Frame number and SOF pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_valid <= 1'b0;
      frame_no  <= '0;
    end else begin
      sof_valid <= sv_n;
      if (load_sof) frame_no <= d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_usbf_token_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_usbf_token_dec
// Description : Self-checking bench for usbf_token_dec: directed packets plus
//               randomized packets checked against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usbf_token_dec;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_active, rx_err;
  logic        token_valid, pid_err, crc5_err, len_err, tmo_err;
  logic [3:0]  token_pid;
  logic [6:0]  token_fadr;
  logic [3:0]  token_endp;
`ifdef USBF_TOKEN_SOF_EN
  logic [10:0] frame_no;
  logic        sof_valid;
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  usbf_token_dec #(.TMO_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .rx_err     (rx_err),
    .token_valid(token_valid),
    .token_pid  (token_pid),
    .token_fadr (token_fadr),
    .token_endp (token_endp),
    .pid_err    (pid_err),
    .crc5_err   (crc5_err),
    .len_err    (len_err),
`ifdef USBF_TOKEN_SOF_EN
    .frame_no   (frame_no),
    .sof_valid  (sof_valid),
`endif
    .tmo_err    (tmo_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int drop_cyc = 0;
  int last_tv_cyc = 0;
  int n_tv = 0, n_pe = 0, n_ce = 0, n_le = 0, n_te = 0, n_sv = 0;

  logic [7:0]  pkt [4];
  logic [3:0]  exp_pid;
  logic [6:0]  exp_fadr;
  logic [3:0]  exp_endp;
  logic [10:0] exp_frame;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC5 as a polynomial remainder: preset ones occupy x^15..x^11, message
  // bit d[0] is the highest-order coefficient, divisor x^5+x^2+1.
  function automatic logic [4:0] ref_crc5(input logic [10:0] dd);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v[15-i] = dd[i];
    v[15:11] = v[15:11] ^ 5'b11111;
    for (int k = 15; k >= 5; k--)
      if (v[k]) v[k -: 6] = v[k -: 6] ^ 6'b100101;
    return v[4:0];
  endfunction

  // Pulse monitor, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (token_valid) begin n_tv = n_tv + 1; last_tv_cyc = cyc; end
    if (pid_err)  n_pe = n_pe + 1;
    if (crc5_err) n_ce = n_ce + 1;
    if (len_err)  n_le = n_le + 1;
    if (tmo_err)  n_te = n_te + 1;
`ifdef USBF_TOKEN_SOF_EN
    if (sof_valid) n_sv = n_sv + 1;
`endif
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // long_at: index before which a timeout-length gap is inserted (nb = trailing).
  task automatic send_pkt(input int nb, input int err_at, input int long_at);
    int g;
    @(negedge clk);
    rx_active = 1'b1; rx_valid = 1'b0; rx_err = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= nb; i++) begin
      g = (i == long_at) ? TMO + 4 : int'($urandom_range(0, 2));
      repeat (g) @(negedge clk);
      if (i == err_at) begin
        rx_err = 1'b1; @(negedge clk); rx_err = 1'b0;
      end
      if (i < nb) begin
        rx_valid = 1'b1; rx_data = pkt[i];
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'($urandom);
      end
    end
    rx_active = 1'b0;
    drop_cyc  = cyc;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_pkt(input string nm, input int nb, input int err_at, input int long_at);
    int b_tv, b_pe, b_ce, b_le, b_te, b_sv;
    int e_tv, e_pe, e_ce, e_le, e_te, e_sv;
    logic [10:0] dd;
    logic [3:0]  p;
    b_tv = n_tv; b_pe = n_pe; b_ce = n_ce; b_le = n_le; b_te = n_te; b_sv = n_sv;
    e_tv = 0; e_pe = 0; e_ce = 0; e_le = 0; e_te = 0; e_sv = 0;
    send_pkt(nb, err_at, long_at);
    p  = pkt[0][3:0];
    dd = {pkt[2][2:0], pkt[1]};
    if (err_at >= 0) begin
      // packet discarded silently
    end else if (long_at >= 0) begin
      e_te = 1;
    end else if (pkt[0][7:4] != ~pkt[0][3:0]) begin
      e_pe = 1;
    end else if (!(p == 4'h1 || p == 4'h9 || p == 4'hD || (SOF_EN && p == 4'h5))) begin
      // valid non-token PID: nothing
    end else if (nb != 3) begin
      e_le = 1;
    end else if (ref_crc5(dd) != pkt[2][7:3]) begin
      e_ce = 1;
    end else if (p == 4'h5) begin
      e_sv = 1; exp_frame = dd;
    end else begin
      e_tv = 1; exp_pid = p; exp_fadr = dd[6:0]; exp_endp = dd[10:7];
    end
    check_eq({nm, ".token_valid"}, n_tv - b_tv, e_tv);
    check_eq({nm, ".pid_err"},     n_pe - b_pe, e_pe);
    check_eq({nm, ".crc5_err"},    n_ce - b_ce, e_ce);
    check_eq({nm, ".len_err"},     n_le - b_le, e_le);
    check_eq({nm, ".tmo_err"},     n_te - b_te, e_te);
    check_eq({nm, ".pid"},  token_pid,  exp_pid);
    check_eq({nm, ".fadr"}, token_fadr, exp_fadr);
    check_eq({nm, ".endp"}, token_endp, exp_endp);
    if (e_tv == 1) check_eq({nm, ".latency"}, last_tv_cyc - drop_cyc, 2);
`ifdef USBF_TOKEN_SOF_EN
    check_eq({nm, ".sof_valid"}, n_sv - b_sv, e_sv);
    check_eq({nm, ".frame_no"},  frame_no, exp_frame);
`endif
  endtask

  task automatic make_good(input logic [7:0] p0, input logic [7:0] b1, input logic [2:0] hi);
    pkt[0] = p0; pkt[1] = b1;
    pkt[2] = {ref_crc5({hi, b1}), hi};
    pkt[3] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string nm);
    check_eq({nm, ".token_valid"}, token_valid, 0);
    check_eq({nm, ".pid"},  token_pid, 0);
    check_eq({nm, ".fadr"}, token_fadr, 0);
    check_eq({nm, ".endp"}, token_endp, 0);
    check_eq({nm, ".errs"}, {pid_err, crc5_err, len_err, tmo_err}, 0);
`ifdef USBF_TOKEN_SOF_EN
    check_eq({nm, ".sof"}, {sof_valid, frame_no}, 0);
`endif
  endtask

  initial begin
    int sel, r, nb, err_at, b_all;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_active = 1'b0; rx_err = 1'b0;
    exp_pid = '0; exp_fadr = '0; exp_endp = '0; exp_frame = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good OUT token: addr 5, endpoint 5.
    make_good(8'hE1, 8'h85, 3'b010);
    run_pkt("good_out", 3, -1, -1);
    check_eq("good_out.fadr_const", token_fadr, 7'h05);
    check_eq("good_out.endp_const", token_endp, 4'h5);

    // Same packet with one CRC bit flipped.
    pkt[2][7:3] = pkt[2][7:3] ^ 5'b00001;
    run_pkt("crc_bad", 3, -1, -1);

    make_good(8'hE2, 8'h11, 3'b001);
    run_pkt("pid_bad", 3, -1, -1);
    make_good(8'hC3, 8'h11, 3'b001);
    run_pkt("data0", 3, -1, -1);

    make_good(8'h69, 8'h3C, 3'b101);
    run_pkt("len2", 2, -1, -1);
    run_pkt("len4", 4, -1, -1);
    run_pkt("rx_err", 3, 2, -1);
    run_pkt("tmo", 2, -1, 2);

    // Reset while the decoder sits in TK1; remainder of packet must vanish.
    b_all = n_tv + n_pe + n_ce + n_le + n_te + n_sv;
    make_good(8'h2D, 8'h7E, 3'b110);
    @(negedge clk); rx_active = 1'b1;
    @(negedge clk); rx_valid = 1'b1; rx_data = pkt[0];
    @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
    #1;
    check_all_zero("rst_tk1");
    exp_pid = '0; exp_fadr = '0; exp_endp = '0; exp_frame = '0;
    @(negedge clk); rst = 1'b0; rx_valid = 1'b1; rx_data = pkt[1];
    @(negedge clk); rx_data = pkt[2];
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rx_active = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_tk1.no_pulse", n_tv + n_pe + n_ce + n_le + n_te + n_sv - b_all, 0);
    check_all_zero("rst_tk1.after");

    make_good(8'h2D, 8'h7E, 3'b110);
    run_pkt("post_rst", 3, -1, -1);
    make_good(8'hA5, 8'h34, 3'b011);
    run_pkt("sof", 3, -1, -1);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: pkt[0] = 8'hE1;
        1: pkt[0] = 8'h69;
        2: pkt[0] = 8'h2D;
        3: pkt[0] = 8'hA5;
        4: pkt[0] = 8'hC3;
        default: pkt[0] = 8'($urandom);
      endcase
      pkt[1] = 8'($urandom); pkt[2] = 8'($urandom); pkt[3] = 8'($urandom);
      if ($urandom_range(0, 9) < 7) pkt[2][7:3] = ref_crc5({pkt[2][2:0], pkt[1]});
      r  = int'($urandom_range(0, 9));
      nb = (r < 6) ? 3 : (r < 7) ? 1 : (r < 8) ? 2 : 4;
      err_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb)) : -1;
      run_pkt("rnd", nb, err_at, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
